// File: rtl/gpr_file_pkg.sv
// Shared definitions for the general-purpose register file.
//   - x86 register index encoding (EAX..EDI)
//   - default width parameters
//   - lane_merge(): byte-lane merge of a new value into an old one
package gpr_file_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 3;

  typedef enum logic [GPR_ADDR_W-1:0] {
    REG_EAX = 3'd0,
    REG_ECX = 3'd1,
    REG_EDX = 3'd2,
    REG_EBX = 3'd3,
    REG_ESP = 3'd4,
    REG_EBP = 3'd5,
    REG_ESI = 3'd6,
    REG_EDI = 3'd7
  } gpr_idx_e;

  // The merge works on a fixed wide container so one function serves every
  // register width; callers widen their operands and truncate the result.
  // Register widths up to MERGE_W bits are supported.
  localparam int MERGE_W = 256;
  localparam int MERGE_B = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0] old_val,
    input logic [MERGE_W-1:0] new_val,
    input logic [MERGE_B-1:0] be
  );
    logic [MERGE_W-1:0] res;
    for (int k = 0; k < MERGE_B; k++) begin
      res[k*8 +: 8] = be[k] ? new_val[k*8 +: 8] : old_val[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard for the register file.
//   clk, reset            : clock, synchronous active-high reset
//   wa_*/wb_* en/addr/last : write-back ports; *_last clears the pending bit
//   alloc_en/alloc_addr    : decode request to mark a register pending
//   alloc_ready            : allocation accepted this cycle
//   ra_addr/rb_addr        : read indices; ra_pending/rb_pending their status
//   pending_vec            : raw pending bits
module gpr_scoreboard
  import gpr_file_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic              wa_last,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_last,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ready,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic              ra_pending,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              rb_pending,
  output logic [NUM_REGS-1:0] pending_vec
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_v;
  logic [NUM_REGS-1:0] clr_v;

  // Addresses at or above NUM_REGS match no register, so they never set,
  // clear, report pending, or get an allocation accepted.
  always_comb begin
    clr_v       = '0;
    set_v       = '0;
    alloc_ready = 1'b0;
    ra_pending  = 1'b0;
    rb_pending  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      clr_v[r] = (wa_en && wa_last && (wa_addr == ADDR_W'(r))) ||
                 (wb_en && wb_last && (wb_addr == ADDR_W'(r)));
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      // A completing write frees the slot in the same cycle for back-to-back reuse.
      if (alloc_addr == ADDR_W'(r)) alloc_ready = !pending[r] || clr_v[r];
      if (ra_addr == ADDR_W'(r)) ra_pending = pending[r] && !((BYPASS != 0) && clr_v[r]);
      if (rb_addr == ADDR_W'(r)) rb_pending = pending[r] && !((BYPASS != 0) && clr_v[r]);
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      set_v[r] = alloc_en && alloc_ready && (alloc_addr == ADDR_W'(r));
    end
  end

  // Set wins over clear: the new producer supersedes the completing one.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_v) | set_v;
  end

  assign pending_vec = pending;

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file with two byte-masked write ports, two
// combinational read ports (optional same-cycle bypass) and a pending-write
// scoreboard.
//   clk, reset              : clock, synchronous active-high reset
//   wa_* / wb_*             : write ports A and B (en, addr, be, data, last);
//                             B wins on lanes both ports write
//   ra_addr/ra_data/ra_pending, rb_addr/rb_data/rb_pending : read ports
//   alloc_en/alloc_addr/alloc_ready : mark a register as pending
//   pending_vec             : scoreboard bits
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int BYPASS   = 1,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VEC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wa_en,
  input  logic [ADDR_W-1:0]   wa_addr,
  input  logic [DATA_W/8-1:0] wa_be,
  input  logic [DATA_W-1:0]   wa_data,
  input  logic                wa_last,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W/8-1:0] wb_be,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                wb_last,
  input  logic [ADDR_W-1:0]   ra_addr,
  output logic [DATA_W-1:0]   ra_data,
  output logic                ra_pending,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data,
  output logic                rb_pending,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_addr,
  output logic                alloc_ready,
  output logic [NUM_REGS-1:0] pending_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   nxt  [NUM_REGS];
  logic [NUM_REGS-1:0] wa_sel;
  logic [NUM_REGS-1:0] wb_sel;

  // Decoding against each valid index drops out-of-range writes naturally.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wa_sel[r] = wa_en && (wa_addr == ADDR_W'(r));
      wb_sel[r] = wb_en && (wb_addr == ADDR_W'(r));
    end
  end

  // Next value per register: A merged first, then B on top so B wins
  // shared lanes. This is also exactly the per-lane bypass value.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      nxt[r] = regs[r];
      if (wa_sel[r])
        nxt[r] = DATA_W'(lane_merge(MERGE_W'(nxt[r]), MERGE_W'(wa_data), MERGE_B'(wa_be)));
      if (wb_sel[r])
        nxt[r] = DATA_W'(lane_merge(MERGE_W'(nxt[r]), MERGE_W'(wb_data), MERGE_B'(wb_be)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= RST_VEC[r*DATA_W +: DATA_W];
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= nxt[r];
    end
  end

  // Out-of-range read addresses match nothing and return zero.
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ra_addr == ADDR_W'(r)) ra_data = (BYPASS != 0) ? nxt[r] : regs[r];
      if (rb_addr == ADDR_W'(r)) rb_data = (BYPASS != 0) ? nxt[r] : regs[r];
    end
  end

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .wa_en       (wa_en),
    .wa_addr     (wa_addr),
    .wa_last     (wa_last),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_last     (wb_last),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .ra_addr     (ra_addr),
    .ra_pending  (ra_pending),
    .rb_addr     (rb_addr),
    .rb_pending  (rb_pending),
    .pending_vec (pending_vec)
  );

endmodule

// File: tb/tb_gpr_file.sv
module tb_gpr_file;
  import gpr_file_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT with bypass, EBX resets to 0x888 ----------------
  localparam logic [255:0] RST_IMG = 256'h888 << 96;

  logic        reset, wa_en, wa_last, wb_en, wb_last, alloc_en;
  logic [2:0]  wa_addr, wb_addr, ra_addr, rb_addr, alloc_addr;
  logic [3:0]  wa_be, wb_be;
  logic [31:0] wa_data, wb_data, ra_data, rb_data;
  logic        ra_pending, rb_pending, alloc_ready;
  logic [7:0]  pending_vec;

  gpr_file #(.NUM_REGS(8), .DATA_W(32), .ADDR_W(3), .BYPASS(1), .RST_VEC(RST_IMG)) dut (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_be(wa_be), .wa_data(wa_data), .wa_last(wa_last),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_be(wb_be), .wb_data(wb_data), .wb_last(wb_last),
    .ra_addr(ra_addr), .ra_data(ra_data), .ra_pending(ra_pending),
    .rb_addr(rb_addr), .rb_data(rb_data), .rb_pending(rb_pending),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .pending_vec(pending_vec)
  );

  // ---------------- DUT without bypass, 4-bit addresses ----------------
  logic        z_reset, z_wa_en, z_wa_last, z_wb_en, z_wb_last, z_alloc_en;
  logic [3:0]  z_wa_addr, z_wb_addr, z_ra_addr, z_rb_addr, z_alloc_addr;
  logic [3:0]  z_wa_be, z_wb_be;
  logic [31:0] z_wa_data, z_wb_data, z_ra_data, z_rb_data;
  logic        z_ra_pending, z_rb_pending, z_alloc_ready;
  logic [7:0]  z_pending_vec;

  gpr_file #(.NUM_REGS(8), .DATA_W(32), .ADDR_W(4), .BYPASS(0), .RST_VEC('0)) dut0 (
    .clk(clk), .reset(z_reset),
    .wa_en(z_wa_en), .wa_addr(z_wa_addr), .wa_be(z_wa_be), .wa_data(z_wa_data), .wa_last(z_wa_last),
    .wb_en(z_wb_en), .wb_addr(z_wb_addr), .wb_be(z_wb_be), .wb_data(z_wb_data), .wb_last(z_wb_last),
    .ra_addr(z_ra_addr), .ra_data(z_ra_data), .ra_pending(z_ra_pending),
    .rb_addr(z_rb_addr), .rb_data(z_rb_data), .rb_pending(z_rb_pending),
    .alloc_en(z_alloc_en), .alloc_addr(z_alloc_addr), .alloc_ready(z_alloc_ready),
    .pending_vec(z_pending_vec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          chk;
    bit          rst;
    bit          wa_en;  logic [2:0] wa_addr; logic [3:0] wa_be; logic [31:0] wa_data; bit wa_last;
    bit          wb_en;  logic [2:0] wb_addr; logic [3:0] wb_be; logic [31:0] wb_data; bit wb_last;
    logic [2:0]  ra;     logic [2:0] rb;
    bit          al_en;  logic [2:0] al_addr;
    logic [31:0] e_ra;   logic [31:0] e_rb;
    bit          e_rap;  bit e_rbp;  bit e_ar;  logic [7:0] e_pv;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] ra, rb;
    bit          rap, rbp, ar;
    logic [7:0]  pv;
  } exp_t;

  function automatic vec_t V(
    input bit c, input bit rs,
    input bit ae, input logic [2:0] aa, input logic [3:0] ab, input logic [31:0] ad, input bit al,
    input bit be_, input logic [2:0] ba, input logic [3:0] bb, input logic [31:0] bd, input bit bl,
    input logic [2:0] ra_, input logic [2:0] rb_, input bit ale, input logic [2:0] ala,
    input logic [31:0] era, input logic [31:0] erb, input bit erap, input bit erbp,
    input bit ear, input logic [7:0] epv);
    vec_t v;
    v.chk = c; v.rst = rs;
    v.wa_en = ae; v.wa_addr = aa; v.wa_be = ab; v.wa_data = ad; v.wa_last = al;
    v.wb_en = be_; v.wb_addr = ba; v.wb_be = bb; v.wb_data = bd; v.wb_last = bl;
    v.ra = ra_; v.rb = rb_; v.al_en = ale; v.al_addr = ala;
    v.e_ra = era; v.e_rb = erb; v.e_rap = erap; v.e_rbp = erbp; v.e_ar = ear; v.e_pv = epv;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vecs [NV];
  exp_t sbq [$];

  // Scoreboard checker: expectations are pushed when a row is driven just
  // after a rising edge and compared at the following falling edge.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk($sformatf("v%0d ra_data", e.idx),     ra_data,            e.ra);
      chk($sformatf("v%0d rb_data", e.idx),     rb_data,            e.rb);
      chk($sformatf("v%0d ra_pending", e.idx),  32'(ra_pending),    32'(e.rap));
      chk($sformatf("v%0d rb_pending", e.idx),  32'(rb_pending),    32'(e.rbp));
      chk($sformatf("v%0d alloc_ready", e.idx), 32'(alloc_ready),   32'(e.ar));
      chk($sformatf("v%0d pending_vec", e.idx), 32'(pending_vec),   32'(e.pv));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wa_en = 0; wa_addr = 0; wa_be = 0; wa_data = 0; wa_last = 0;
    wb_en = 0; wb_addr = 0; wb_be = 0; wb_data = 0; wb_last = 0;
    ra_addr = 0; rb_addr = 0; alloc_en = 0; alloc_addr = 0;
    z_reset = 1'b1; z_wa_en = 0; z_wa_addr = 0; z_wa_be = 0; z_wa_data = 0; z_wa_last = 0;
    z_wb_en = 0; z_wb_addr = 0; z_wb_be = 0; z_wb_data = 0; z_wb_last = 0;
    z_ra_addr = 0; z_rb_addr = 0; z_alloc_en = 0; z_alloc_addr = 0;

    //          c rs  wa: en a  be    data          l  wb: en a  be    data          l  ra rb  al  a   e_ra          e_rb          rap rbp ar pv
    vecs[0]  = V(0,1, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 3,0, 0,0, 32'h0,        32'h0,        0,0,0,8'h00);
    vecs[1]  = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 3,0, 0,0, 32'h888,      32'h0,        0,0,1,8'h00);
    vecs[2]  = V(1,0, 1,0,4'hF,32'h12345678, 0, 0,0,4'h0,32'h0,        0, 0,3, 0,0, 32'h12345678, 32'h888,      0,0,1,8'h00);
    vecs[3]  = V(1,0, 0,0,4'h0,32'h0,        0, 1,0,4'h2,32'hAABBCCDD, 0, 0,3, 0,0, 32'h1234CC78, 32'h888,      0,0,1,8'h00);
    vecs[4]  = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 0,1, 0,0, 32'h1234CC78, 32'h0,        0,0,1,8'h00);
    vecs[5]  = V(1,0, 1,3,4'hF,32'h11111111, 0, 1,3,4'h3,32'h22222222, 0, 3,3, 0,0, 32'h11112222, 32'h11112222, 0,0,1,8'h00);
    vecs[6]  = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 3,0, 0,0, 32'h11112222, 32'h1234CC78, 0,0,1,8'h00);
    vecs[7]  = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 1,1, 1,1, 32'h0,        32'h0,        0,0,1,8'h00);
    vecs[8]  = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 1,1, 1,1, 32'h0,        32'h0,        1,1,0,8'h02);
    vecs[9]  = V(1,0, 1,1,4'hF,32'hC1,       1, 0,0,4'h0,32'h0,        0, 1,1, 1,1, 32'hC1,       32'hC1,       0,0,1,8'h02);
    vecs[10] = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 1,1, 0,1, 32'hC1,       32'hC1,       1,1,0,8'h02);
    vecs[11] = V(1,0, 0,0,4'h0,32'h0,        0, 1,1,4'h0,32'hFFFFFFFF, 1, 1,0, 0,1, 32'hC1,       32'h1234CC78, 0,0,1,8'h02);
    vecs[12] = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 1,1, 0,1, 32'hC1,       32'hC1,       0,0,1,8'h00);
    vecs[13] = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 2,2, 1,2, 32'h0,        32'h0,        0,0,1,8'h00);
    vecs[14] = V(0,1, 1,2,4'hF,32'hDEADBEEF, 0, 0,0,4'h0,32'h0,        0, 2,2, 1,2, 32'h0,        32'h0,        0,0,0,8'h00);
    vecs[15] = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 2,3, 0,2, 32'h0,        32'h888,      0,0,1,8'h00);
    vecs[16] = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 0,1, 0,0, 32'h0,        32'h0,        0,0,1,8'h00);
    vecs[17] = V(1,0, 1,4,4'h5,32'hFFFFFFFF, 0, 0,0,4'h0,32'h0,        0, 4,4, 0,0, 32'h00FF00FF, 32'h00FF00FF, 0,0,1,8'h00);
    vecs[18] = V(1,0, 0,0,4'h0,32'h0,        0, 1,4,4'h8,32'h7F000000, 0, 4,4, 0,0, 32'h7FFF00FF, 32'h7FFF00FF, 0,0,1,8'h00);
    vecs[19] = V(1,0, 0,0,4'h0,32'h0,        0, 0,0,4'h0,32'h0,        0, 4,3, 0,0, 32'h7FFF00FF, 32'h888,      0,0,1,8'h00);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst;
      wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_be = vecs[i].wa_be;
      wa_data = vecs[i].wa_data; wa_last = vecs[i].wa_last;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_be = vecs[i].wb_be;
      wb_data = vecs[i].wb_data; wb_last = vecs[i].wb_last;
      ra_addr = vecs[i].ra; rb_addr = vecs[i].rb;
      alloc_en = vecs[i].al_en; alloc_addr = vecs[i].al_addr;
      if (vecs[i].chk) begin
        exp_t e;
        e.idx = i; e.ra = vecs[i].e_ra; e.rb = vecs[i].e_rb;
        e.rap = vecs[i].e_rap; e.rbp = vecs[i].e_rbp; e.ar = vecs[i].e_ar; e.pv = vecs[i].e_pv;
        sbq.push_back(e);
      end
    end
    for (int c = 0; c < 8 && sbq.size() != 0; c++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
    @(posedge clk); #1;
    wa_en = 0; wb_en = 0; alloc_en = 0;

    // ---------------- no-bypass build, wide address ----------------
    z_reset = 1'b0; z_ra_addr = 4'd6; z_rb_addr = 4'd0; z_alloc_addr = 4'd0;
    @(negedge clk);
    chk("z_reset_esi", z_ra_data, 32'h0);
    chk("z_reset_pvec", 32'(z_pending_vec), 32'h0);
    chk("z_reset_ready", 32'(z_alloc_ready), 32'h1);

    @(posedge clk); #1;
    z_wa_en = 1; z_wa_addr = 4'd6; z_wa_be = 4'hF; z_wa_data = 32'h5; z_wa_last = 0;
    @(negedge clk);
    chk("z_esi_write_cycle", z_ra_data, 32'h0);

    @(posedge clk); #1;
    z_wa_en = 0;
    @(negedge clk);
    chk("z_esi_next_cycle", z_ra_data, 32'h5);

    @(posedge clk); #1;
    z_wa_en = 1; z_wa_addr = 4'd9; z_wa_be = 4'hF; z_wa_data = 32'hFFFFFFFF; z_wa_last = 1;
    z_alloc_en = 1; z_alloc_addr = 4'd9; z_ra_addr = 4'd9;
    @(negedge clk);
    chk("z_oor_read", z_ra_data, 32'h0);
    chk("z_oor_pending", 32'(z_ra_pending), 32'h0);
    chk("z_oor_ready", 32'(z_alloc_ready), 32'h0);

    @(posedge clk); #1;
    z_wa_en = 0; z_wa_last = 0; z_alloc_en = 0; z_ra_addr = 4'd1; z_rb_addr = 4'd6;
    @(negedge clk);
    chk("z_oor_no_alias", z_ra_data, 32'h0);
    chk("z_esi_kept", z_rb_data, 32'h5);
    chk("z_oor_pvec", 32'(z_pending_vec), 32'h0);

    @(posedge clk); #1;
    z_alloc_en = 1; z_alloc_addr = 4'd2;
    @(negedge clk);
    chk("z_alloc_edx_ready", 32'(z_alloc_ready), 32'h1);

    @(posedge clk); #1;
    z_alloc_en = 0; z_wa_en = 1; z_wa_addr = 4'd2; z_wa_be = 4'hF; z_wa_data = 32'h77;
    z_wa_last = 1; z_ra_addr = 4'd2;
    @(negedge clk);
    chk("z_edx_old_data", z_ra_data, 32'h0);
    chk("z_edx_pend_nobyp", 32'(z_ra_pending), 32'h1);
    chk("z_edx_ready_on_clr", 32'(z_alloc_ready), 32'h1);
    chk("z_edx_pvec", 32'(z_pending_vec), 32'h04);

    @(posedge clk); #1;
    z_wa_en = 0; z_wa_last = 0;
    @(negedge clk);
    chk("z_edx_new_data", z_ra_data, 32'h77);
    chk("z_edx_pend_clr", 32'(z_ra_pending), 32'h0);
    chk("z_edx_pvec_clr", 32'(z_pending_vec), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
